powertrain_sequencer: RTL and testbench
=======================================

POWERTRAIN_SEQUENCER -- requirements
Module: powertrain_sequencer

Interface
REQ-001 SHALL have parameter CRANK_TICKS, default 2, number of tick_1sec pulses spent cranking.
REQ-002 SHALL have parameter SHIFT_LOCK_CYC, default 4, clk cycles after an accepted shift during which further shift requests are rejected.
REQ-003 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  single-cycle start/stop pulse, debounced upstream.
- shift_req  in  1  single-cycle gear-change request.
- shift_target  in  4  requested gear: 3=P, 6=R, 9=N, 12=D.
- is_brake_normal  in  1  normal brake pressed.
- is_brake_hard  in  1  hard brake pressed.
- speed  in  8  vehicle speed, km/h.
- fuel  in  8  fuel level, %.
- tick_1sec  in  1  one-cycle pulse every second.
- engine_on  out  1  engine running.
- current_gear  out  4  gear code, same encoding as shift_target.
- cranking  out  1  high while in CRANK.
- shift_reject  out  1  one-cycle pulse on a refused shift_req.
- stalled  out  1  sticky flag: engine stopped by fuel exhaustion.

Function
REQ-004 The engine FSM SHALL have exactly the states OFF, CRANK and RUN.
REQ-005 OFF->CRANK SHALL occur on btn_start only when a brake input is high, current_gear is P or N, and fuel>0; otherwise btn_start SHALL be ignored.
REQ-006 CRANK SHALL count tick_1sec pulses and enter RUN on the cycle after the CRANK_TICKS-th pulse.
REQ-007 btn_start in CRANK SHALL abort to OFF.
REQ-008 RUN->OFF SHALL occur on btn_start only when speed==0; btn_start in RUN with speed>0 SHALL be ignored.
REQ-009 fuel==0 in RUN or CRANK SHALL force OFF and set stalled.
REQ-010 stalled SHALL clear on the next accepted OFF->CRANK transition.
REQ-011 engine_on SHALL be registered and equal 1 only in RUN; cranking SHALL equal 1 only in CRANK.
REQ-012 A shift_req SHALL be evaluated in the cycle it is asserted; on acceptance current_gear SHALL update at the next clk edge.
REQ-013 A shift_target not in {3,6,9,12} SHALL be rejected.
REQ-014 shift_target equal to current_gear SHALL be a no-op, with no reject pulse and no lockout.
REQ-015 Leaving P SHALL require engine_on=1 and a brake input high.
REQ-016 Entering P or R SHALL require speed==0.
REQ-017 R->D SHALL require speed==0.
REQ-018 D<->N and R->N SHALL be allowed at any speed when engine_on=1.
REQ-019 In OFF or CRANK, only a shift into P SHALL be accepted, and only when speed==0.
REQ-020 An accepted shift SHALL load the lockout counter with SHIFT_LOCK_CYC; while the counter is nonzero, every shift_req SHALL be rejected.
REQ-021 shift_reject SHALL pulse high for exactly one cycle, the cycle after a rejected shift_req.
REQ-022 When btn_start and shift_req are asserted in the same cycle, btn_start SHALL be processed and shift_req SHALL be rejected.
REQ-023 Counters SHALL saturate and never wrap; the CRANK tick counter SHALL clear on every FSM state change.

Reset
REQ-024 rst_n low SHALL immediately force: state OFF, engine_on=0, cranking=0, current_gear=3 (P), shift_reject=0, stalled=0, all counters 0.
REQ-025 Reset asserted mid-crank or mid-lockout SHALL abandon the operation with no residual effect after release.

Configuration
REQ-026 Macro AUTO_PARK_EN, when defined, SHALL force current_gear to P on the cycle after any RUN->OFF transition where speed==0.
REQ-027 Without AUTO_PARK_EN, current_gear SHALL be retained across engine shutdown.

Structure
REQ-028 A shared package SHALL hold the gear code constants (GEAR_P=3, GEAR_R=6, GEAR_N=9, GEAR_D=12) and the engine-state enumeration, for use by this block and the vehicle physics block.
REQ-029 Shift-legality checking SHALL be a sub-module named gear_rule_check (combinational: current gear, target, speed, brakes, engine_on -> accept).

Verification
REQ-030 Start sequence: brake=1, gear P, fuel=50, btn_start, two tick_1sec -> cranking for 2 ticks, then engine_on=1.
REQ-031 Shift out of P: RUN, speed=0, no brake, shift_target=12 -> shift_reject pulse, gear stays 3; same request with brake=1 -> gear 12 next cycle.
REQ-032 Reverse interlock: D, speed=20, shift_target=6 -> reject; shift_target=9 -> gear 9.
REQ-033 Lockout: accepted shift, then a second request 2 cycles later -> reject; a request 5 cycles after the accepted shift -> accepted.
REQ-034 Fuel starvation: RUN, fuel drops to 0 -> engine_on=0 and stalled=1 next cycle; btn_start with fuel=0 -> stays OFF.
REQ-035 Reset during CRANK: rst_n low -> OFF, gear 3, all outputs 0 immediately; with AUTO_PARK_EN, D at speed 0 plus btn_start -> OFF, then gear 3.

Source files
------------

// File: rtl/powertrain_sequencer_pkg.sv
// Shared gear codes and engine-state enumeration for the powertrain sequencer
// and the vehicle physics block.
package powertrain_sequencer_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        CRANK = 2'd1,
        RUN   = 2'd2
    } engine_state_t;

    function automatic logic gear_valid(input logic [3:0] g);
        return (g == GEAR_P) || (g == GEAR_R) || (g == GEAR_N) || (g == GEAR_D);
    endfunction

endpackage

// File: rtl/powertrain_sequencer_gear_rule_check.sv
// Combinational shift-legality check: decides whether a requested gear change
// is permitted given speed, brakes and engine state.
module gear_rule_check
    import powertrain_sequencer_pkg::*;
(
    input  logic [3:0] i_cur_gear,
    input  logic [3:0] i_target,
    input  logic [7:0] i_speed,
    input  logic       i_brake,
    input  logic       i_engine_on,
    output logic       o_accept
);

    logic w_stopped;

    assign w_stopped = (i_speed == 8'd0);

    always_comb begin
        o_accept = 1'b0;
        if (!gear_valid(i_target)) begin
            o_accept = 1'b0;
        end else if (i_target == i_cur_gear) begin
            o_accept = 1'b1;
        end else if (!i_engine_on) begin
            // With the engine not running only parking a stopped car is allowed
            o_accept = (i_target == GEAR_P) && w_stopped;
        end else begin
            o_accept = 1'b1;
            if ((i_cur_gear == GEAR_P) && !i_brake)
                o_accept = 1'b0;
            if (((i_target == GEAR_P) || (i_target == GEAR_R)) && !w_stopped)
                o_accept = 1'b0;
            if ((i_cur_gear == GEAR_R) && (i_target == GEAR_D) && !w_stopped)
                o_accept = 1'b0;
        end
    end

endmodule

// File: rtl/powertrain_sequencer.sv
// Engine start/stop sequencer with gear selector and shift lockout.
// Optional macro AUTO_PARK_EN: park the gearbox after a standstill shutdown.
module powertrain_sequencer
    import powertrain_sequencer_pkg::*;
#(
    parameter int CRANK_TICKS    = 2,
    parameter int SHIFT_LOCK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       shift_req,
    input  logic [3:0] shift_target,
    input  logic       is_brake_normal,
    input  logic       is_brake_hard,
    input  logic [7:0] speed,
    input  logic [7:0] fuel,
    input  logic       tick_1sec,
    output logic       engine_on,
    output logic [3:0] current_gear,
    output logic       cranking,
    output logic       shift_reject,
    output logic       stalled
);

    localparam int TICK_W = $clog2(CRANK_TICKS + 2);
    localparam int LOCK_W = $clog2(SHIFT_LOCK_CYC + 2);
    localparam logic [TICK_W-1:0] CRANK_MAX = TICK_W'(CRANK_TICKS);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(SHIFT_LOCK_CYC);

    engine_state_t     r_state;
    engine_state_t     w_state_next;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_next, w_tick_inc;
    logic [LOCK_W-1:0] r_lock_cnt, w_lock_next;
    logic [3:0]        r_gear, w_gear_next;
    logic              r_engine_on, r_cranking, r_reject, r_stalled;
    logic              w_brake, w_fuel_empty, w_start_ok, w_stall_set;
    logic              w_rule_accept, w_shift_noop, w_shift_rej, w_shift_ok;

    assign w_brake      = is_brake_normal | is_brake_hard;
    assign w_fuel_empty = (fuel == 8'd0);
    assign w_tick_inc   = (r_tick_cnt == CRANK_MAX) ? r_tick_cnt : r_tick_cnt + 1'b1;

    gear_rule_check u_rule (
        .i_cur_gear  (r_gear),
        .i_target    (shift_target),
        .i_speed     (speed),
        .i_brake     (w_brake),
        .i_engine_on (r_engine_on),
        .o_accept    (w_rule_accept)
    );

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_start_ok   = 1'b0;
        w_stall_set  = 1'b0;
        case (r_state)
            OFF: begin
                if (btn_start && w_brake && !w_fuel_empty &&
                    ((r_gear == GEAR_P) || (r_gear == GEAR_N))) begin
                    w_state_next = CRANK;
                    w_start_ok   = 1'b1;
                end
            end
            CRANK: begin
                if (w_fuel_empty) begin
                    w_state_next = OFF;
                    w_stall_set  = 1'b1;
                end else if (btn_start) begin
                    w_state_next = OFF;
                end else if (tick_1sec) begin
                    if (w_tick_inc >= CRANK_MAX)
                        w_state_next = RUN;
                    else
                        w_tick_next = w_tick_inc;
                end
            end
            RUN: begin
                if (w_fuel_empty) begin
                    w_state_next = OFF;
                    w_stall_set  = 1'b1;
                end else if (btn_start && (speed == 8'd0)) begin
                    w_state_next = OFF;
                end
            end
            default: w_state_next = OFF;
        endcase
        if (w_state_next != r_state)
            w_tick_next = '0;
    end

    // A start/stop press in the same cycle always wins over a shift request
    always_comb begin
        w_shift_noop = shift_req && (shift_target == r_gear);
        w_shift_rej  = shift_req && (btn_start || (r_lock_cnt != '0) ||
                                     (!w_shift_noop && !w_rule_accept));
        w_shift_ok   = shift_req && !w_shift_rej && !w_shift_noop;
        w_gear_next  = w_shift_ok ? shift_target : r_gear;
        if (w_shift_ok)
            w_lock_next = LOCK_LOAD;
        else if (r_lock_cnt != '0)
            w_lock_next = r_lock_cnt - 1'b1;
        else
            w_lock_next = '0;
    end

`ifdef AUTO_PARK_EN
    logic r_park_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_park_pending <= 1'b0;
            r_gear         <= GEAR_P;
        end else begin
            r_park_pending <= (r_state == RUN) && (w_state_next == OFF) && (speed == 8'd0);
            r_gear         <= r_park_pending ? GEAR_P : w_gear_next;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_gear <= GEAR_P;
        else
            r_gear <= w_gear_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= OFF;
            r_tick_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_engine_on <= 1'b0;
            r_cranking  <= 1'b0;
            r_reject    <= 1'b0;
            r_stalled   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_next;
            r_lock_cnt  <= w_lock_next;
            r_engine_on <= (w_state_next == RUN);
            r_cranking  <= (w_state_next == CRANK);
            r_reject    <= w_shift_rej;
            if (w_stall_set)
                r_stalled <= 1'b1;
            else if (w_start_ok)
                r_stalled <= 1'b0;
        end
    end

    assign engine_on    = r_engine_on;
    assign cranking     = r_cranking;
    assign current_gear = r_gear;
    assign shift_reject = r_reject;
    assign stalled      = r_stalled;

endmodule

// File: tb/tb_powertrain_sequencer.sv
// Scenario testbench for powertrain_sequencer; shift expectations go through a
// scoreboard queue and are popped when the DUT responds.
module tb_powertrain_sequencer;
    import powertrain_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, btn_start, shift_req, is_brake_normal, is_brake_hard, tick_1sec;
    logic [3:0] shift_target;
    logic [7:0] speed, fuel;
    logic       engine_on, cranking, shift_reject, stalled;
    logic [3:0] current_gear;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gear;
        logic       rej;
    } exp_t;
    exp_t sb[$];

    powertrain_sequencer #(.CRANK_TICKS(2), .SHIFT_LOCK_CYC(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_start       (btn_start),
        .shift_req       (shift_req),
        .shift_target    (shift_target),
        .is_brake_normal (is_brake_normal),
        .is_brake_hard   (is_brake_hard),
        .speed           (speed),
        .fuel            (fuel),
        .tick_1sec       (tick_1sec),
        .engine_on       (engine_on),
        .current_gear    (current_gear),
        .cranking        (cranking),
        .shift_reject    (shift_reject),
        .stalled         (stalled)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_btn();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_1sec = 1'b1;
        step();
        tick_1sec = 1'b0;
    endtask

    task automatic send_shift(input logic [3:0] tgt, input logic [3:0] eg, input logic er);
        exp_t e;
        e.gear = eg;
        e.rej  = er;
        sb.push_back(e);
        shift_target = tgt;
        shift_req    = 1'b1;
        step();
        shift_req    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++;
        if (engine_on !== 1'b0 || cranking !== 1'b0 || current_gear !== GEAR_P ||
            shift_reject !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL reset_state eng=%b crk=%b gear=%0d rej=%b stl=%b expected 0 0 3 0 0",
                     engine_on, cranking, current_gear, shift_reject, stalled);
        end
        rst_n = 1'b1;
        step();
        $display("reset released gear=%0d", current_gear);
    endtask

    task automatic test_start();
        is_brake_normal = 1'b0;
        pulse_btn();
        checks++;
        if (cranking !== 1'b0) begin
            errors++;
            $display("FAIL start_no_brake cranking=%b expected 0", cranking);
        end
        is_brake_normal = 1'b1;
        pulse_btn();
        checks++;
        if (cranking !== 1'b1 || engine_on !== 1'b0) begin
            errors++;
            $display("FAIL start_crank crk=%b eng=%b expected 1 0", cranking, engine_on);
        end
        idle(3);
        pulse_tick();
        checks++;
        if (cranking !== 1'b1) begin
            errors++;
            $display("FAIL crank_tick1 cranking=%b expected 1", cranking);
        end
        pulse_tick();
        checks++;
        if (engine_on !== 1'b1 || cranking !== 1'b0) begin
            errors++;
            $display("FAIL crank_done eng=%b crk=%b expected 1 0", engine_on, cranking);
        end
        is_brake_normal = 1'b0;
        $display("start sequence eng=%b", engine_on);
    endtask

    task automatic test_shift_rules();
        logic [3:0] t_tgt [11] = '{4'd12, 4'd12, 4'd6, 4'd9, 4'd7, 4'd9, 4'd6, 4'd12, 4'd9, 4'd12, 4'd3};
        logic       t_brk [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] t_spd [11] = '{8'd0, 8'd0, 8'd20, 8'd20, 8'd20, 8'd20, 8'd0, 8'd5, 8'd5, 8'd30, 8'd30};
        logic [3:0] t_eg  [11] = '{4'd3, 4'd12, 4'd12, 4'd9, 4'd9, 4'd9, 4'd6, 4'd6, 4'd9, 4'd12, 4'd12};
        logic       t_er  [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int         t_gap [11] = '{6, 6, 6, 6, 6, 0, 6, 6, 6, 6, 6};
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            is_brake_normal = t_brk[i];
            speed           = t_spd[i];
            send_shift(t_tgt[i], t_eg[i], t_er[i]);
            e = sb.pop_front();
            checks++;
            if (current_gear !== e.gear || shift_reject !== e.rej) begin
                errors++;
                $display("FAIL shift_row%0d gear=%0d rej=%b expected gear=%0d rej=%b",
                         i, current_gear, shift_reject, e.gear, e.rej);
            end
            $display("shift row%0d tgt=%0d spd=%0d gear=%0d rej=%b", i, t_tgt[i], speed,
                     current_gear, shift_reject);
            idle(t_gap[i]);
        end
        is_brake_normal = 1'b0;
    endtask

    task automatic test_lockout();
        exp_t e;
        speed = 8'd30;
        send_shift(GEAR_N, GEAR_N, 1'b0);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL lock_first gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        step();
        send_shift(GEAR_D, GEAR_N, 1'b1);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL lock_reject gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        checks++;
        step();
        if (shift_reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_width rej=%b expected 0", shift_reject);
        end
        step();
        send_shift(GEAR_D, GEAR_D, 1'b0);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL lock_expired gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        $display("lockout sequence gear=%0d", current_gear);
    endtask

    task automatic test_same_cycle();
        exp_t e;
        idle(6);
        speed     = 8'd30;
        btn_start = 1'b1;
        send_shift(GEAR_N, GEAR_D, 1'b1);
        btn_start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej || engine_on !== 1'b1) begin
            errors++;
            $display("FAIL btn_and_shift gear=%0d rej=%b eng=%b expected gear=%0d rej=%b eng=1",
                     current_gear, shift_reject, engine_on, e.gear, e.rej);
        end
        $display("btn+shift gear=%0d rej=%b", current_gear, shift_reject);
    endtask

    task automatic test_fuel();
        exp_t e;
        idle(6);
        fuel = 8'd0;
        step();
        checks++;
        if (engine_on !== 1'b0 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL fuel_stall eng=%b stl=%b expected 0 1", engine_on, stalled);
        end
        speed = 8'd0;
        send_shift(GEAR_N, GEAR_D, 1'b1);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL off_shift_n gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        step();
        send_shift(GEAR_P, GEAR_P, 1'b0);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL off_shift_p gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        is_brake_normal = 1'b1;
        pulse_btn();
        checks++;
        if (cranking !== 1'b0 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL start_no_fuel crk=%b stl=%b expected 0 1", cranking, stalled);
        end
        fuel = 8'd50;
        pulse_btn();
        checks++;
        if (cranking !== 1'b1 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears_stall crk=%b stl=%b expected 1 0", cranking, stalled);
        end
        $display("fuel sequence crk=%b stl=%b", cranking, stalled);
    endtask

    task automatic test_reset_mid_crank();
        pulse_tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (engine_on !== 1'b0 || cranking !== 1'b0 || current_gear !== GEAR_P ||
            shift_reject !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL async_reset eng=%b crk=%b gear=%0d rej=%b stl=%b expected 0 0 3 0 0",
                     engine_on, cranking, current_gear, shift_reject, stalled);
        end
        step();
        rst_n = 1'b1;
        step();
        pulse_btn();
        pulse_tick();
        checks++;
        if (cranking !== 1'b1 || engine_on !== 1'b0) begin
            errors++;
            $display("FAIL crank_after_reset crk=%b eng=%b expected 1 0", cranking, engine_on);
        end
        pulse_btn();
        checks++;
        if (cranking !== 1'b0 || engine_on !== 1'b0) begin
            errors++;
            $display("FAIL crank_abort crk=%b eng=%b expected 0 0", cranking, engine_on);
        end
        pulse_btn();
        pulse_tick();
        checks++;
        if (cranking !== 1'b1) begin
            errors++;
            $display("FAIL tick_cnt_cleared crk=%b expected 1", cranking);
        end
        pulse_tick();
        checks++;
        if (engine_on !== 1'b1) begin
            errors++;
            $display("FAIL restart_run eng=%b expected 1", engine_on);
        end
        $display("reset-in-crank sequence eng=%b", engine_on);
    endtask

    task automatic test_shutdown();
        exp_t       e;
        logic [3:0] park_gear;
`ifdef AUTO_PARK_EN
        park_gear = GEAR_P;
`else
        park_gear = GEAR_D;
`endif
        speed = 8'd0;
        send_shift(GEAR_D, GEAR_D, 1'b0);
        e = sb.pop_front();
        checks++;
        if (current_gear !== e.gear || shift_reject !== e.rej) begin
            errors++;
            $display("FAIL shift_to_d gear=%0d rej=%b expected gear=%0d rej=%b",
                     current_gear, shift_reject, e.gear, e.rej);
        end
        idle(6);
        speed = 8'd5;
        pulse_btn();
        checks++;
        if (engine_on !== 1'b1) begin
            errors++;
            $display("FAIL stop_while_moving eng=%b expected 1", engine_on);
        end
        speed = 8'd0;
        pulse_btn();
        checks++;
        if (engine_on !== 1'b0) begin
            errors++;
            $display("FAIL stop_at_rest eng=%b expected 0", engine_on);
        end
        idle(2);
        checks++;
        if (current_gear !== park_gear) begin
            errors++;
            $display("FAIL gear_after_stop gear=%0d expected %0d", current_gear, park_gear);
        end
        $display("shutdown gear=%0d", current_gear);
    endtask

    initial begin
        rst_n           = 1'b0;
        btn_start       = 1'b0;
        shift_req       = 1'b0;
        shift_target    = GEAR_P;
        is_brake_normal = 1'b0;
        is_brake_hard   = 1'b0;
        speed           = 8'd0;
        fuel            = 8'd50;
        tick_1sec       = 1'b0;
        test_reset();
        test_start();
        test_shift_rules();
        test_lockout();
        test_same_cycle();
        test_fuel();
        test_reset_mid_crank();
        test_shutdown();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
